// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for an external loadable up-counter.
// Loads a start value, increments until the counter equals the end value,
// then pulses done. Supports pause, abort (clears the counter) and a sticky
// wrap-around flag. Optional prescaler enabled by COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] end_val,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] count_q,
   output logic             cnt_load,
   output logic             cnt_inc,
   output logic             cnt_reset,
   output logic [WIDTH-1:0] cnt_in,
   output logic             busy,
   output logic             done,
   output logic             wrapped
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_COUNT = 3'd2,
      S_DONE  = 3'd3,
      S_CLEAR = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] end_q;
   logic             wrapped_q;
   logic             tick;
   logic             accept;

   assign accept  = (state == S_IDLE) && start;
   assign wrapped = wrapped_q;

`ifdef COUNTER_CTRL_PRESCALE_EN
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] presc;

   assign tick = (presc == PW'(PRESCALE - 1));

   // Prescaler: cleared entering COUNT or on abort, frozen by pause
   always_ff @(posedge clock) begin
      if (reset) begin
         presc <= '0;
      end else if (state == S_LOAD) begin
         presc <= '0;
      end else if (state == S_COUNT) begin
         if (abort)
            presc <= '0;
         else if (!pause)
            presc <= tick ? '0 : presc + PW'(1);
      end
   end
`else
   logic unused_prescale;

   assign tick            = 1'b1;
   assign unused_prescale = (PRESCALE == 0);
`endif

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Run parameters latched on an accepted start
   always_ff @(posedge clock) begin
      if (reset) begin
         start_q <= '0;
         end_q   <= '0;
      end else if (accept) begin
         start_q <= start_val;
         end_q   <= end_val;
      end
   end

   // Sticky wrap flag: set when an increment leaves all-ones
   always_ff @(posedge clock) begin
      if (reset)
         wrapped_q <= 1'b0;
      else if (accept)
         wrapped_q <= 1'b0;
      else if (cnt_inc && (count_q == {WIDTH{1'b1}}))
         wrapped_q <= 1'b1;
   end

   // Next-state and output decode
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_reset = 1'b0;
      cnt_in    = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_LOAD;
         end
         S_LOAD: begin
            busy   = 1'b1;
            cnt_in = start_q;
            if (abort) begin
               state_nxt = S_CLEAR;
            end else begin
               cnt_load  = 1'b1;
               state_nxt = S_COUNT;
            end
         end
         S_COUNT: begin
            busy = 1'b1;
            if (abort)
               state_nxt = S_CLEAR;
            else if (count_q == end_q)
               state_nxt = S_DONE;
            else if (!pause)
               cnt_inc = tick;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         S_CLEAR: begin
            busy      = 1'b1;
            cnt_reset = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: randomized self-checking bench for counter_ctrl.
// Includes a behavioural model of the external counter and a run-level
// reference that tracks increment "work" consumed versus required.
module tb_counter_ctrl;

`ifdef COUNTER_CTRL_PRESCALE_EN
   localparam int PSC = 4;
`else
   localparam int PSC = 1;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] start_val;
   logic [3:0] end_val;
   logic       pause;
   logic       abort;
   logic [3:0] count_q = 4'd0;
   logic       cnt_load;
   logic       cnt_inc;
   logic       cnt_reset;
   logic [3:0] cnt_in;
   logic       busy;
   logic       done;
   logic       wrapped;

   int n_cmp = 0;
   int n_err = 0;

   counter_ctrl #(.WIDTH(4), .PRESCALE(4)) dut (
      .clock(clock), .reset(reset), .start(start), .start_val(start_val),
      .end_val(end_val), .pause(pause), .abort(abort), .count_q(count_q),
      .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_reset(cnt_reset),
      .cnt_in(cnt_in), .busy(busy), .done(done), .wrapped(wrapped)
   );

   always #5 clock = ~clock;

   // External counter: priority load > inc > reset
   always @(posedge clock) begin
      if (cnt_load)
         count_q <= cnt_in;
      else if (cnt_inc)
         count_q <= count_q + 4'd1;
      else if (cnt_reset)
         count_q <= 4'd0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_ctl(input string ph, input logic l, input logic i, input logic r,
                          input logic b, input logic d);
      chk({ph, ".cnt_load"}, cnt_load, l);
      chk({ph, ".cnt_inc"}, cnt_inc, i);
      chk({ph, ".cnt_reset"}, cnt_reset, r);
      chk({ph, ".busy"}, busy, b);
      chk({ph, ".done"}, done, d);
   endtask

   // One run: abort_at/reset_at index the LOAD cycle as 0 and COUNT cycles from 1
   task automatic run(input logic [3:0] sv, input logic [3:0] ev, input int pause_first,
                      input int pause_pct, input int abort_at, input int reset_at);
      int   ticks;
      int   consumed;
      int   k;
      int   outcome;  // 0 done, 1 clear, 2 reset, 3 timeout
      logic [3:0] mc;
      logic mw;
      logic p;
      logic a;
      logic inc_e;
      logic at_end;
      ticks = int'(4'(ev - sv)) * PSC;

      @(negedge clock);
      start = 1'b1; start_val = sv; end_val = ev;
      pause = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
      #1;
      chk_ctl("idle", 0, 0, 0, 0, 0);
      chk("idle.cnt_in", cnt_in, 0);
      @(posedge clock);
      mw = 1'b0;

      @(negedge clock);
      start = 1'($urandom_range(0, 1)); start_val = 4'($urandom); end_val = 4'($urandom);
      pause = 1'($urandom_range(0, 1)); abort = (abort_at == 0);
      #1;
      chk_ctl("load", !abort, 0, 0, 1, 0);
      chk("load.cnt_in", cnt_in, sv);
      chk("load.wrapped", wrapped, mw);
      @(posedge clock);

      outcome = 1;
      mc = sv;
      consumed = 0;
      k = 0;
      if (abort_at != 0) begin
         outcome = 3;
         while (k < 400) begin
            k++;
            @(negedge clock);
            p = (k <= pause_first) || ($urandom_range(0, 99) < pause_pct);
            a = (k == abort_at);
            start = 1'($urandom_range(0, 1)); start_val = 4'($urandom); end_val = 4'($urandom);
            pause = p; abort = a; reset = (k == reset_at);
            #1;
            if (k == reset_at) begin
               @(posedge clock);
               outcome = 2;
               break;
            end
            at_end = (consumed == ticks);
            inc_e  = 1'b0;
            if (!a && !at_end && !p) begin
               consumed++;
               inc_e = ((consumed % PSC) == 0);
            end
            chk("count.count_q", count_q, mc);
            chk("count.wrapped", wrapped, mw);
            chk_ctl("count", 0, inc_e, 0, 1, 0);
            if (inc_e) begin
               if (mc == 4'hF) mw = 1'b1;
               mc = mc + 4'd1;
            end
            @(posedge clock);
            if (a) begin outcome = 1; break; end
            if (at_end) begin outcome = 0; break; end
         end
      end

      case (outcome)
         0: begin
            @(negedge clock);
            start = 1'b1; start_val = 4'($urandom); abort = 1'($urandom_range(0, 1));
            #1;
            chk_ctl("done", 0, 0, 0, 0, 1);
            chk("done.count_q", count_q, ev);
            chk("done.wrapped", wrapped, mw);
            @(negedge clock);
            start = 1'b0; abort = 1'b0;
            #1;
            chk_ctl("after_done", 0, 0, 0, 0, 0);
         end
         1: begin
            @(negedge clock);
            abort = 1'b0; start = 1'($urandom_range(0, 1));
            #1;
            chk_ctl("clear", 0, 0, 1, 1, 0);
            @(negedge clock);
            start = 1'b0;
            #1;
            chk_ctl("after_clear", 0, 0, 0, 0, 0);
            chk("after_clear.count_q", count_q, 0);
            chk("after_clear.wrapped", wrapped, mw);
         end
         2: begin
            @(negedge clock);
            reset = 1'b0; start = 1'b0; abort = 1'b0;
            #1;
            chk_ctl("after_reset", 0, 0, 0, 0, 0);
            chk("after_reset.cnt_in", cnt_in, 0);
            chk("after_reset.wrapped", wrapped, 0);
         end
         default: begin
            chk("run_timeout", 1, 0);
            @(negedge clock);
            reset = 1'b1; start = 1'b0; abort = 1'b0;
            @(negedge clock);
            reset = 1'b0;
         end
      endcase
   endtask

   initial begin
      int abort_at;
      int reset_at;
      reset = 1'b1; start = 1'b0; start_val = 4'd0; end_val = 4'd0;
      pause = 1'b0; abort = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         start_val = 4'($urandom); end_val = 4'($urandom);
         abort = 1'($urandom_range(0, 1)); pause = 1'($urandom_range(0, 1));
         #1;
         chk_ctl("reset_idle", 0, 0, 0, 0, 0);
         chk("reset_idle.cnt_in", cnt_in, 0);
         chk("reset_idle.wrapped", wrapped, 0);
      end
      abort = 1'b0;

      run(4'd3,  4'd7,  0, 0, -1, -1);
      run(4'd14, 4'd1,  0, 0, -1, -1);
      run(4'd5,  4'd5,  0, 0, -1, -1);
      run(4'd0,  4'd2,  3, 0, -1, -1);
      run(4'd2,  4'd12, 0, 0,  3, -1);
      run(4'd2,  4'd12, 0, 0, -1,  3);
      run(4'd9,  4'd4,  0, 0,  0, -1);

      for (int r = 0; r < 40; r++) begin
         abort_at = -1;
         reset_at = -1;
         if ($urandom_range(0, 4) == 0) abort_at = int'($urandom_range(0, 12));
         else if ($urandom_range(0, 6) == 0) reset_at = int'($urandom_range(1, 12));
         run(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)) * 25, abort_at, reset_at);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
